// File: rtl/poly_comp_seq.sv
// poly_comp_seq: Horner-rule temperature-compensation polynomial sequencer (Q2.14)
//   Ports: clk, rst_n (sync, active-low), start, temp[15:0] -> latched operand;
//          coeff_rd/coeff_addr/coeff <-> NV_mem read port (1-cycle latency);
//          mult_a/mult_b -> external saturating multiplier, sat_prod <- its product;
//          result[15:0] registered result, done one-cycle pulse, busy = not IDLE.
module poly_comp_seq #(
   parameter int NUM_COEFF = 4,
   parameter int ADDR_W    = 3,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       temp,
   output logic              coeff_rd,
   output logic [ADDR_W-1:0] coeff_addr,
   input  logic [15:0]       coeff,
   output logic [15:0]       mult_a,
   output logic [15:0]       mult_b,
   input  logic [15:0]       sat_prod,
   output logic [15:0]       result,
   output logic              done,
   output logic              busy
);
   localparam int IW = $clog2(NUM_COEFF);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(BASE_ADDR + NUM_COEFF - 1);
   typedef enum logic [1:0] {IDLE, FETCH, STEP, DONE} state_t;
   state_t state;
   logic [15:0] acc, temp_reg, sum;
   logic [IW-1:0] idx;
   logic rd_top, rd_idx, rd_dec;
   // 17-bit sum overflows exactly when its two top bits disagree
   function automatic logic [15:0] satadd(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
      return (s[16] != s[15]) ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
   endfunction
   assign sum    = satadd(sat_prod, coeff);
   assign mult_a = acc;
   assign mult_b = temp_reg;
   assign busy   = state != IDLE;
   // Read strobe is combinational so the coefficient arrives the following cycle;
   // in STEP it already targets the next (decremented) index.
   always_comb begin
      rd_top     = state == IDLE && start;
      rd_idx     = state == FETCH;
      rd_dec     = state == STEP && idx != '0;
      coeff_rd   = rst_n && (rd_top || rd_idx || rd_dec);
      coeff_addr = !coeff_rd ? BASE : rd_top ? TOP : BASE + ADDR_W'(rd_idx ? idx : idx - IW'(1));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         temp_reg <= '0;
         idx      <= '0;
         result   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               temp_reg <= temp;
               idx      <= IW'(NUM_COEFF - 2);
               state    <= FETCH;
            end
            FETCH: begin
               acc   <= coeff;
               state <= STEP;
            end
            STEP: begin
               acc <= sum;
               if (idx != '0) idx <= idx - IW'(1);
               else begin
                  result <= sum;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_poly_comp_seq.sv
// tb_poly_comp_seq: table-driven check of poly_comp_seq with NV_mem and multiplier models
module tb_poly_comp_seq;
   localparam int N = 4;
   logic clk = 0, rst_n = 0, start = 0, coeff_rd, done, busy;
   logic [15:0] temp = 0, coeff = 0, mult_a, mult_b, sat_prod, result;
   logic [2:0] coeff_addr;
   logic [15:0] mem [8];
   logic signed [31:0] prod, shf;
   int total = 0, bad = 0;
   logic [15:0] prev_res = 0;
   typedef struct packed {
      logic [15:0]          t;
      logic [3:0][15:0]     c;
      logic [3:0][15:0]     a;
   } vec_t;
   vec_t vt [4];

   poly_comp_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .temp(temp),
      .coeff_rd(coeff_rd), .coeff_addr(coeff_addr), .coeff(coeff),
      .mult_a(mult_a), .mult_b(mult_b), .sat_prod(sat_prod),
      .result(result), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (coeff_rd) coeff <= mem[coeff_addr];

   always_comb begin
      prod = $signed(mult_a) * $signed(mult_b);
      shf = prod >>> 14;
      sat_prod = shf > 32'sd32767 ? 16'h7FFF : shf < -32'sd32768 ? 16'h8000 : shf[15:0];
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One evaluation from cycle 0 (start) through cycle N+1 (done).
   // ign: cycle in which a stray start is pulsed; rc: cycle in which rst_n is pulled low.
   task automatic run(input int v, input int ign, input int rc);
      for (int i = 0; i < N; i++) mem[i] = vt[v].c[i];
      for (int c = 0; c <= N + 1; c++) begin
         start = (c == 0) || (c == ign);
         temp  = (c == 0) ? vt[v].t : 16'h2000;
         rst_n = (c != rc);
         @(negedge clk);
         if (c != rc) begin
            chk($sformatf("rd c%0d", c), {15'd0, coeff_rd}, {15'd0, c <= N - 1});
            chk($sformatf("addr c%0d", c), {13'd0, coeff_addr}, c <= N - 1 ? 16'(N - 1 - c) : 16'd0);
         end
         chk($sformatf("busy c%0d", c), {15'd0, busy}, {15'd0, c >= 1 && c <= N + 1});
         chk($sformatf("done c%0d", c), {15'd0, done}, {15'd0, c == N + 1});
         chk($sformatf("result c%0d", c), result, c == N + 1 ? vt[v].a[3] : prev_res);
         if (c >= 1) chk($sformatf("mult_b c%0d", c), mult_b, vt[v].t);
         if (c >= 2) chk($sformatf("acc c%0d", c), mult_a, vt[v].a[c - 2]);
         @(posedge clk); #1;
         if (c == rc) begin
            rst_n = 1; start = 0;
            @(negedge clk);
            chk("rst busy", {15'd0, busy}, 16'd0);
            chk("rst done", {15'd0, done}, 16'd0);
            chk("rst result", result, 16'd0);
            chk("rst acc", mult_a, 16'd0);
            chk("rst temp", mult_b, 16'd0);
            @(posedge clk); #1;
            prev_res = 0;
            return;
         end
      end
      start = 0;
      prev_res = vt[v].a[3];
   endtask

   initial begin
      vt[0] = '{t: 16'h4000, c: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
                a: {16'h0A00, 16'h0900, 16'h0700, 16'h0400}};
      vt[1] = '{t: 16'h2000, c: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
                a: {16'h0340, 16'h0480, 16'h0500, 16'h0400}};
      vt[2] = '{t: 16'h4000, c: {4{16'h3000}},
                a: {16'h7FFF, 16'h7FFF, 16'h6000, 16'h3000}};
      vt[3] = '{t: 16'h4000, c: {4{16'hC000}},
                a: {16'h8000, 16'h8000, 16'h8000, 16'hC000}};
      for (int i = 4; i < 8; i++) mem[i] = 16'hDEAD;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset busy", {15'd0, busy}, 16'd0);
      chk("reset done", {15'd0, done}, 16'd0);
      chk("reset rd", {15'd0, coeff_rd}, 16'd0);
      chk("reset addr", {13'd0, coeff_addr}, 16'd0);
      chk("reset result", result, 16'd0);
      chk("reset acc", mult_a, 16'd0);
      chk("reset temp", mult_b, 16'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) run(i, -1, -1);
      run(0, 2, -1);
      run(1, -1, -1);
      run(1, -1, 3);
      run(1, -1, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
